code_loader: RTL
================

// Module: code_loader
// PURPOSE
//   Write side of the instruction memory: the CPU only reads code memory by PC; this block fills it.
//   Takes a byte stream (from the serial receiver), parses one load frame and writes 32-bit words to code memory.
//   Holds the CPU stopped (cpu_hold) from frame start until a frame loads with a valid checksum.
//   Frame: SYNC_BYTE, count lo, count hi (words, LE), count*4 payload bytes (each word LE), checksum.
//   Checksum byte = XOR of both count bytes and all payload bytes.
// PARAMETERS
//   CODE_WORDS  512    code memory depth in 32-bit words
//   ADDR_W      9      code address width, $clog2(CODE_WORDS)
//   SYNC_BYTE   8'hA5  frame start marker
// PORTS
//   clk          in   1         clock; all logic on posedge
//   reset        in   1         synchronous, active-high reset
//   rx_data      in   8         incoming byte
//   rx_valid     in   1         rx_data valid
//   rx_ready     out  1         loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//   code_we      out  1         code memory write strobe, one cycle per word
//   code_waddr   out  ADDR_W    code memory word address
//   code_wdata   out  32        code memory write data
//   cpu_hold     out  1         1 = CPU must stay in reset
//   load_done    out  1         one-cycle pulse: frame loaded, checksum good
//   load_err     out  1         sticky error flag
//   words_loaded out  ADDR_W+1  words written in current or last frame
// BEHAVIOUR
//   Reset: state IDLE; code_we, code_waddr, code_wdata, cpu_hold, load_done, load_err, words_loaded = 0; rx_ready = 1.
//   States: IDLE -> LEN0 -> LEN1 -> DATA <-> WRITE -> CSUM -> IDLE. Transitions only on accepted bytes, except WRITE.
//   IDLE: non-sync bytes discarded. On SYNC_BYTE: cpu_hold<=1, load_err<=0, words_loaded<=0, addr<=0, csum<=0 -> LEN0.
//   LEN0/LEN1: capture count lo/hi, XOR into csum.
//     count > CODE_WORDS: load_err<=1, -> IDLE, cpu_hold stays 1, no writes.
//     count == 0: -> CSUM.
//     otherwise: -> DATA.
//   DATA: byte index 0..3 shifts in LE (byte0 = bits 7:0); each byte XORed into csum. Accepting byte 3 -> WRITE.
//   WRITE: exactly one cycle. code_we=1, code_waddr=addr, code_wdata=word, rx_ready=0.
//     code_we occurs the cycle after byte 3 is accepted. addr and words_loaded then increment.
//     -> CSUM if words_loaded reaches count, else -> DATA.
//   rx_ready = 1 in every state except WRITE. Gaps in rx_valid only stall; they never change the result.
//   CSUM: accepted byte compared to csum.
//     Match: load_done pulses in the next cycle, cpu_hold<=0, -> IDLE.
//     Mismatch: load_err<=1, cpu_hold stays 1, no load_done, -> IDLE.
//   load_err clears only on the next SYNC_BYTE or on reset.
//   No resync: a SYNC_BYTE value seen inside a frame is treated as data.
//   code_waddr never wraps; the count check bounds it to CODE_WORDS-1.
//   code_waddr/code_wdata hold their last values when code_we=0.
//   Reset mid-frame: immediate return to reset state; no further writes; cpu_hold drops to 0; partial contents stay in memory.
// TESTING
//   1. After reset, send A5 02 00 13 00 00 00 93 00 10 00 92
//      -> writes [0]=0x00000013, [1]=0x00100093; load_done 1 pulse; cpu_hold 1->0; words_loaded=2.
//   2. Same frame with checksum 00 -> both words written, load_err=1, cpu_hold=1, no load_done.
//      Then send the frame from test 1 -> load_err clears on A5 and the load completes.
//   3. A5 01 02 (count 513) -> load_err=1 after LEN1, zero code_we, cpu_hold=1.
//   4. Bytes 00 FF then the frame from test 1, with random 0-5 cycle rx_valid gaps
//      -> leading bytes ignored; result identical to test 1; rx_ready low exactly 1 cycle per write.
//   5. A5 00 00 00 -> load_done pulse, no code_we, words_loaded=0, cpu_hold=0.
//   6. reset asserted after 6 payload bytes of the frame from test 1
//      -> next cycle IDLE, cpu_hold=0; only [0] written; no further code_we.

Source files
------------

// File: rtl/code_loader.sv
// Code memory loader: parses one framed byte stream (sync, word count, LE payload, XOR checksum)
// into 32-bit code memory writes and holds the CPU in reset until a frame loads cleanly.
module code_loader #(
    parameter int          CODE_WORDS = 512,
    parameter int          ADDR_W     = 9,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              code_we,
    output logic [ADDR_W-1:0] code_waddr,
    output logic [31:0]       code_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM
    } state_t;

    localparam logic [15:0] MAX_COUNT = 16'(CODE_WORDS);

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [7:0]          count_lo;
    logic [15:0]         count_full;
    logic [ADDR_W:0]     count_words;
    logic [ADDR_W:0]     words_next;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          csum;
    logic [23:0]         word_buf;
    logic [1:0]          byte_idx;

    assign rx_ready   = (state != WRITE);
    assign accept     = rx_valid & rx_ready;
    assign count_full = {rx_data, count_lo};
    assign words_next = words_loaded + (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next = LEN0;
                end
            end
            LEN0: begin
                if (accept) begin
                    state_next = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    if (count_full > MAX_COUNT) begin
                        state_next = IDLE;
                    end else if (count_full == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (words_next == count_words) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath; code_we is registered so it is high exactly during the WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_we      <= 1'b0;
            code_waddr   <= '0;
            code_wdata   <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            count_lo     <= '0;
            count_words  <= '0;
            addr         <= '0;
            csum         <= '0;
            word_buf     <= '0;
            byte_idx     <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        cpu_hold     <= 1'b1;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        addr         <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        count_lo <= rx_data;
                        csum     <= csum ^ rx_data;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        csum        <= csum ^ rx_data;
                        count_words <= count_full[ADDR_W:0];
                        if (count_full > MAX_COUNT) begin
                            load_err <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            code_we    <= 1'b1;
                            code_waddr <= addr;
                            code_wdata <= {rx_data, word_buf};
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end
                end
                WRITE: begin
                    code_we      <= 1'b0;
                    addr         <= addr + ADDR_W'(1);
                    words_loaded <= words_next;
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
